// File: rtl/up_host_seq_if.sv
// Processor-side bus of the host sequencer: Init/Enter/Input strobes out, Halt/Output back.
interface up_host_seq_if;
  logic       Init;
  logic       Enter;
  logic [7:0] Input;
  logic       Halt;
  logic [7:0] Output;

  modport master (output Init, Enter, Input, input Halt, Output);
  modport slave  (input Init, Enter, Input, output Halt, Output);
endinterface

// File: rtl/up_host_seq.sv
// Host sequencer: feeds two operands to a GCD-style processor and collects the halted result; ~21 cycles to WAIT_HALT, start ignored while busy.
// Macro UP_HOST_CHECK_EN adds a subtractive reference GCD checker that gates DONE and drives chk_mismatch.
module up_host_seq #(
  parameter int SETUP_CYC   = 4,
  parameter int ENTER_CYC   = 2,
  parameter int GAP_CYC     = 8,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              start,
  input  logic [7:0]        opA,
  input  logic [7:0]        opB,
  up_host_seq_if.master     proc,
  output logic              busy,
  output logic              done,
  output logic [7:0]        result,
  output logic [1:0]        err,
  output logic              chk_mismatch
);

  localparam int PH_SG  = (SETUP_CYC > GAP_CYC) ? SETUP_CYC : GAP_CYC;
  localparam int PH_MAX = (ENTER_CYC > PH_SG) ? ENTER_CYC : PH_SG;
  localparam int CNT_W  = $clog2(PH_MAX + 1);
  localparam int TO_W   = $clog2(TIMEOUT_CYC + 1);

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] ENTER_LAST = CNT_W'(ENTER_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYC - 1);
  localparam logic [TO_W-1:0]  TO_FULL    = TO_W'(TIMEOUT_CYC);

  typedef enum logic [3:0] {
    IDLE, INIT, SETUP_A, PULSE_A, GAP, SETUP_B, PULSE_B, WAIT_HALT, DONE
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [TO_W-1:0]  to_cnt, to_n;
  logic [7:0]       a_q, b_q, input_q;
  logic             halt_seen;
  logic             accept, zero_start, timeout, capture, halted, chk_ready;

  assign proc.Init  = (state == INIT);
  assign proc.Enter = (state == PULSE_A) || (state == PULSE_B);
  assign proc.Input = input_q;
  assign busy       = (state != IDLE);
  assign halted     = proc.Halt || halt_seen;

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    to_n       = to_cnt;
    accept     = 1'b0;
    zero_start = 1'b0;
    timeout    = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        to_n  = '0;
        if (start) begin
          if ((opA == 8'd0) || (opB == 8'd0)) begin
            zero_start = 1'b1;
          end else begin
            accept  = 1'b1;
            state_n = INIT;
          end
        end
      end
      INIT: begin
        cnt_n   = '0;
        state_n = SETUP_A;
      end
      SETUP_A: begin
        if (cnt == SETUP_LAST) begin
          cnt_n   = '0;
          state_n = PULSE_A;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      PULSE_A: begin
        if (cnt == ENTER_LAST) begin
          cnt_n   = '0;
          state_n = GAP;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_n   = '0;
          state_n = SETUP_B;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      SETUP_B: begin
        if (cnt == SETUP_LAST) begin
          cnt_n   = '0;
          state_n = PULSE_B;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      PULSE_B: begin
        if (cnt == ENTER_LAST) begin
          cnt_n   = '0;
          to_n    = '0;
          state_n = WAIT_HALT;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      WAIT_HALT: begin
        // Halt is captured once; afterwards we only wait for the checker.
        capture = proc.Halt && !halt_seen;
        if (halted) begin
          if (chk_ready) state_n = DONE;
        end else if ((to_cnt + TO_W'(1)) == TO_FULL) begin
          timeout = 1'b1;
          to_n    = '0;
          state_n = IDLE;
        end else begin
          to_n = to_cnt + TO_W'(1);
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state     <= IDLE;
      cnt       <= '0;
      to_cnt    <= '0;
      a_q       <= 8'd0;
      b_q       <= 8'd0;
      input_q   <= 8'd0;
      result    <= 8'd0;
      err       <= 2'd0;
      done      <= 1'b0;
      halt_seen <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      to_cnt <= to_n;
      done   <= zero_start || timeout || (state_n == DONE);
      if (accept) begin
        a_q       <= opA;
        b_q       <= opB;
        err       <= 2'd0;
        halt_seen <= 1'b0;
      end
      if (zero_start) err <= 2'd1;
      if (timeout)    err <= 2'd2;
      if (capture) begin
        result    <= proc.Output;
        halt_seen <= 1'b1;
      end
      // Input only moves at the start of a setup window, never around an Enter edge.
      if ((state_n == SETUP_A) && (state != SETUP_A)) input_q <= a_q;
      if ((state_n == SETUP_B) && (state != SETUP_B)) input_q <= b_q;
    end
  end

`ifdef UP_HOST_CHECK_EN
  logic [7:0] chk_x, chk_y;
  logic [7:0] final_res;

  assign chk_ready = (chk_x == chk_y);
  assign final_res = capture ? proc.Output : result;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      chk_x        <= 8'd0;
      chk_y        <= 8'd0;
      chk_mismatch <= 1'b0;
    end else begin
      if (accept) begin
        chk_x        <= opA;
        chk_y        <= opB;
        chk_mismatch <= 1'b0;
      end else if (chk_x > chk_y) begin
        chk_x <= chk_x - chk_y;
      end else if (chk_y > chk_x) begin
        chk_y <= chk_y - chk_x;
      end
      if ((state == WAIT_HALT) && (state_n == DONE)) begin
        chk_mismatch <= (final_res != chk_x);
      end
    end
  end
`else
  assign chk_ready    = 1'b1;
  assign chk_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_up_host_seq.sv
// Directed bench for up_host_seq: normal runs, zero operand, timeout, reset mid-pulse, ignored start/Halt.
module tb_up_host_seq;
  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] opA, opB;
  logic       busy, done, chk_mismatch;
  logic [7:0] result;
  logic [1:0] err;

  up_host_seq_if pif();

  up_host_seq dut (
    .CLOCK        (clk),
    .RESET        (rst),
    .start        (start),
    .opA          (opA),
    .opB          (opB),
    .proc         (pif.master),
    .busy         (busy),
    .done         (done),
    .result       (result),
    .err          (err),
    .chk_mismatch (chk_mismatch)
  );

  always #5 clk = ~clk;

`ifdef UP_HOST_CHECK_EN
  localparam bit CHK_ON = 1'b1;
`else
  localparam bit CHK_ON = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int cyc_cnt, n_pulse, init_cnt, viol, cur_len;
  int plen[4];
  int prise[4];
  logic [7:0] pval[4];
  logic       prev_enter = 1'b0;
  logic [7:0] prev_input = 8'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One clock, then sample and track Enter pulses (length, data, rise time, Input stability).
  task automatic cyc();
    @(posedge clk);
    #1;
    cyc_cnt++;
    if (pif.Init === 1'b1) init_cnt++;
    if (pif.Enter === 1'b1 && !prev_enter) begin
      if (n_pulse < 4) begin
        pval[n_pulse]  = pif.Input;
        prise[n_pulse] = cyc_cnt;
      end
      cur_len = 1;
    end else if (pif.Enter === 1'b1) begin
      cur_len++;
      if (pif.Input !== prev_input) viol++;
    end else if (prev_enter) begin
      if (pif.Input !== prev_input) viol++;
      if (n_pulse < 4) plen[n_pulse] = cur_len;
      n_pulse++;
    end
    prev_enter = (pif.Enter === 1'b1);
    prev_input = pif.Input;
  endtask

  task automatic clear_mon();
    n_pulse  = 0;
    init_cnt = 0;
    viol     = 0;
    cyc_cnt  = 0;
    cur_len  = 0;
  endtask

  task automatic run(input logic [7:0] a, input logic [7:0] b, input logic [7:0] outv,
                     input logic [7:0] exp_res, input bit noise, input bit exp_mis);
    int k;
    clear_mon();
    opA = a; opB = b; start = 1'b1;
    cyc();
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_init", pif.Init, 1);
    check("start_err_clr", err, 0);
    k = 0;
    while (n_pulse < 2 && k < 100) begin
      if (noise && n_pulse == 1) begin
        pif.Halt = 1'b1; pif.Output = 8'hEE;
      end
      cyc();
      k++;
    end
    pif.Halt = 1'b0;
    check("enter_pulses", n_pulse, 2);
    check("a_rise_cyc", prise[0], 6);
    check("b_rise_cyc", prise[1], 20);
    check("a_len", plen[0], 2);
    check("b_len", plen[1], 2);
    check("a_val", pval[0], a);
    check("b_val", pval[1], b);
    check("input_stable", viol, 0);
    check("init_once", init_cnt, 1);
    if (noise) begin
      opA = 8'd3; opB = 8'd9; start = 1'b1;
    end
    repeat (3) cyc();
    check("wait_busy", busy, 1);
    check("wait_nodone", done, 0);
    start = 1'b0;
    pif.Halt = 1'b1; pif.Output = outv;
    cyc();
    pif.Halt = 1'b0;
    check("done_pulse", done, 1);
    check("done_busy", busy, 1);
    check("result", result, exp_res);
    check("done_err", err, 0);
    check("chk_mismatch", chk_mismatch, exp_mis);
    cyc();
    check("done_drop", done, 0);
    check("idle_busy", busy, 0);
    check("result_hold", result, exp_res);
  endtask

  initial begin
    int k;
    rst = 1'b1; start = 1'b0; opA = 8'd0; opB = 8'd0;
    pif.Halt = 1'b0; pif.Output = 8'd0;
    clear_mon();
    repeat (3) cyc();
    check("rst_init", pif.Init, 0);
    check("rst_enter", pif.Enter, 0);
    check("rst_input", pif.Input, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_err", err, 0);
    check("rst_chk", chk_mismatch, 0);
    rst = 1'b0;
    cyc();

    // Normal pair with a stray Halt outside WAIT_HALT.
    run(8'd12, 8'd18, 8'd6, 8'd6, 1'b1, 1'b0);

    // Zero operand is rejected in IDLE.
    clear_mon();
    opA = 8'd0; opB = 8'd9; start = 1'b1;
    cyc();
    start = 1'b0;
    check("zero_done", done, 1);
    check("zero_err", err, 1);
    check("zero_busy", busy, 0);
    repeat (5) cyc();
    check("zero_no_init", init_cnt, 0);
    check("zero_no_enter", n_pulse + cur_len, 0);
    check("zero_done_drop", done, 0);
    check("zero_result", result, 6);

    // Timeout with Halt held low.
    clear_mon();
    opA = 8'd5; opB = 8'd10; start = 1'b1;
    cyc();
    start = 1'b0;
    check("to_err_clr", err, 0);
    k = 0;
    while (n_pulse < 2 && k < 100) begin cyc(); k++; end
    k = 0;
    while (err == 2'd0 && k < 5000) begin cyc(); k++; end
    check("to_cycles", k, 4096);
    check("to_err", err, 2);
    check("to_done", done, 1);
    check("to_busy", busy, 0);
    check("to_result", result, 6);
    cyc();
    check("to_done_drop", done, 0);

    // Reset in PULSE_A, with a start presented on the same edge.
    clear_mon();
    opA = 8'd12; opB = 8'd18; start = 1'b1;
    cyc();
    start = 1'b0;
    k = 0;
    while (pif.Enter !== 1'b1 && k < 50) begin cyc(); k++; end
    check("in_pulse_a", pif.Enter, 1);
    rst = 1'b1; start = 1'b1; opA = 8'd3; opB = 8'd6;
    cyc();
    check("mid_rst_enter", pif.Enter, 0);
    check("mid_rst_init", pif.Init, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_result", result, 0);
    check("mid_rst_err", err, 0);
    rst = 1'b0; start = 1'b0;
    repeat (30) cyc();
    check("no_resume", n_pulse, 1);
    check("no_resume_busy", busy, 0);

    // Restart after reset; start pulsed during WAIT_HALT is ignored.
    run(8'd7, 8'd21, 8'd7, 8'd7, 1'b1, 1'b0);

    // Wrong processor answer.
    run(8'd12, 8'd18, 8'd5, 8'd5, 1'b0, CHK_ON);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
